seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit multiplexed seven-segment display driver sitting directly downstream of `freqcnt`. Consumes the BCD digits `freq0`..`freq3` and the `rangedisp` flag and time-multiplexes them onto one common-anode display: one active-low anode strobe per digit, shared active-low segment and decimal-point lines. Inputs are snapshotted once per scan frame, so a count update from `freqcnt` never tears a displayed frame.

## Interface
- `SCAN_DIV`, 12500: sysclk cycles per digit slot; 50 MHz sysclk gives 4 kHz digit rate, 1 kHz frame rate; legal range 2..65535.
- `sysclk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `freq0`  in  4  BCD units digit, shown on `an[0]`.
- `freq1`  in  4  BCD tens digit, `an[1]`.
- `freq2`  in  4  BCD hundreds digit, `an[2]`.
- `freq3`  in  4  BCD thousands digit (most significant), `an[3]`.
- `rangedisp`  in  1  1 = kHz range; lights DP on digit 2, rendering `d3d2.d1d0`.
- `an`  out  4  active-low digit enables, exactly one low while scanning.
- `seg`  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1  active-low decimal point.

## Operation
- Prescaler `pcnt` (16 bit) counts 0..`SCAN_DIV`-1 and wraps; `tick` = (`pcnt` == `SCAN_DIV`-1).
- Digit index `idx` (2 bit): reset value 3; increments mod 4 on `tick`, so the first tick after reset selects digit 0.
- Snapshot registers `s0`..`s3` and `srange` (reset 0) load `freq0..freq3` and `rangedisp` on the tick where `idx` goes 3->0. They are stable for the whole frame.
- Decoder: BCD 0-9 use the standard patterns (active-low), e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000. Codes 10-15 show a dash, 7'b0111111 (g only).
- `dp` = 0 only when the selected digit is 2 and `srange` = 1; otherwise 1.
- Output registers `an`, `seg`, `dp` update on `tick` from the new `idx` and the (possibly just-loaded) snapshot. `an` = ~(4'b0001 << new idx).
- Reset values: `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1, `pcnt` = 0, `idx` = 3. The display stays fully dark until the first tick.
- Reset asserted mid-frame immediately forces all of the above reset values, asynchronously, with no glitch-through of old segments.
- The input digits are not range-checked beyond dash display. `rangedisp` changes take effect at the next frame only.

## Timing
- First tick occurs on the edge where `pcnt` = `SCAN_DIV`-1, i.e. the `SCAN_DIV`-th rising edge after `rst` deasserts. Outputs change on that same edge (registered, 0-cycle after tick).
- Each digit is held exactly `SCAN_DIV` cycles. A frame is 4*`SCAN_DIV` cycles.
- Input-to-display latency is at most 4*`SCAN_DIV` cycles to the snapshot, plus up to 3*`SCAN_DIV` cycles until the digit's slot.
- Input changes that are not coincident with a frame-start tick are ignored until the next frame. An input change on the same edge as the frame-start tick is not captured; the sampled value is the pre-edge value.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit 3 is blanked (`seg` = 7'b1111111, `an` still strobes) if `s3` = 0.
  - Digit 2 is blanked if `s3` = `s2` = 0 and `srange` = 0.
  - Digit 1 is blanked if `s3` = `s2` = `s1` = 0 and `srange` = 0.
  - Digit 0 is never blanked.
  - When `srange` = 1, only digit 3 can blank. Digits carrying or following the DP always show.
- Not defined: all four digits are always decoded, so zeros are shown.

## Test plan
- `SCAN_DIV` = 4, reset 130 ns, inputs 1,2,5,0 (freq3..0), `rangedisp` = 1.
  - First `an` = 4'b1110 with `seg` = 7'b1000000 (0) at the 4th edge after reset.
  - Then 4'b1101/`seg` for 5, 4'b1011/`seg` for 2 with `dp` = 0, 4'b0111/`seg` for 1.
  - Each slot lasts 4 cycles.
- Change `freq0` 0->7 during the digit-2 slot -> digit 0 still shows 0 until the next frame-start tick, then shows 7'b1111000.
- `freq2` = 4'hC -> digit 2 shows 7'b0111111 (dash).
- Assert `rst` mid-slot, between clock edges -> `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1 immediately. After release, dark for exactly 4 cycles.
- With `SEG7_LZ_BLANK_EN`, inputs 0,0,4,2, `rangedisp` = 0 -> digits 3 and 2 show all-ones `seg` while `an` strobes; digits 1 and 0 show 4 and 2. With `rangedisp` = 1, digit 2 shows 0 with `dp` = 0.
- `SCAN_DIV` = 2 -> `idx` advances every 2 cycles and the frame is 8 cycles, with no skipped or doubled digit.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 12500
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [3:0] freq0,
    input  logic [3:0] freq1,
    input  logic [3:0] freq2,
    input  logic [3:0] freq3,
    input  logic       rangedisp,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0]      pcnt_q, pcnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic             srange_q, srange_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick, blank;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        tick     = (pcnt_q == LAST);
        pcnt_d   = tick ? 16'd0 : pcnt_q + 16'd1;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        snap_d   = snap_q;
        srange_d = srange_q;
        // Frame start: the slot about to be shown must already see the new snapshot.
        if (tick && idx_q == 2'd3) begin
            snap_d   = {freq3, freq2, freq1, freq0};
            srange_d = rangedisp;
        end
`ifdef SEG7_LZ_BLANK_EN
        case (idx_d)
            2'd3:    blank = (snap_d[3] == 4'd0);
            2'd2:    blank = (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0) && !srange_d;
            2'd1:    blank = (snap_d[3] == 4'd0) && (snap_d[2] == 4'd0) &&
                             (snap_d[1] == 4'd0) && !srange_d;
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        an_d  = ~(4'b0001 << idx_d);
        seg_d = blank ? 7'b1111111 : dec(snap_d[idx_d]);
        dp_d  = !(idx_d == 2'd2 && srange_d);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pcnt_q   <= 16'd0;
            idx_q    <= 2'd3;
            snap_q   <= '0;
            srange_q <= 1'b0;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            srange_q <= srange_d;
            if (tick) begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (SCAN_DIV 4 and 2) against a slot-arithmetic model.
// Define SEG7_LZ_BLANK_EN for both RTL and bench to exercise leading-zero blanking.
module tb_seg7_scan;
    logic       sysclk = 1'b0;
    logic       rst;
    logic [3:0] freq0, freq1, freq2, freq3;
    logic       rangedisp;
    logic [3:0] an4, an2;
    logic [6:0] seg4, seg2;
    logic       dp4, dp2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] DARK = {4'b1111, 7'b1111111, 1'b1};
    localparam logic [6:0] SEGTAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    localparam int DIVS [2] = '{4, 2};

    seg7_scan #(.SCAN_DIV(4)) u_d4 (
        .sysclk(sysclk), .rst(rst), .freq0(freq0), .freq1(freq1), .freq2(freq2),
        .freq3(freq3), .rangedisp(rangedisp), .an(an4), .seg(seg4), .dp(dp4));
    seg7_scan #(.SCAN_DIV(2)) u_d2 (
        .sysclk(sysclk), .rst(rst), .freq0(freq0), .freq1(freq1), .freq2(freq2),
        .freq3(freq3), .rangedisp(rangedisp), .an(an2), .seg(seg2), .dp(dp2));

    always #5 sysclk = ~sysclk;

    // Model: rising edges since reset release decide the slot; frame starts capture inputs.
    int              edges [2];
    logic [3:0][3:0] snap  [2];
    logic            srng  [2];

    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                edges[m] <= 0;
                snap[m]  <= '0;
                srng[m]  <= 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                edges[m] <= edges[m] + 1;
                if ((edges[m] + 1) % DIVS[m] == 0 && ((edges[m] + 1) / DIVS[m] - 1) % 4 == 0) begin
                    snap[m] <= {freq3, freq2, freq1, freq0};
                    srng[m] <= rangedisp;
                end
            end
        end
    end

    function automatic logic [11:0] expect_out(input int n, input int d,
                                               input logic [3:0][3:0] s, input logic r);
        int         dig;
        logic       blk;
        logic [3:0] a;
        if (n < d) return DARK;
        dig = (n / d - 1) % 4;
        blk = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        if (dig == 3) blk = (s[3] == 0);
        if (dig == 2) blk = (s[3] == 0 && s[2] == 0 && !r);
        if (dig == 1) blk = (s[3] == 0 && s[2] == 0 && s[1] == 0 && !r);
`endif
        a = 4'b1111;
        a[dig] = 1'b0;
        return {a, blk ? 7'b1111111 : SEGTAB[s[dig]], !(dig == 2 && r)};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    always @(negedge sysclk) begin
        chk("model_d4", {an4, seg4, dp4}, expect_out(edges[0], 4, snap[0], srng[0]));
        chk("model_d2", {an2, seg2, dp2}, expect_out(edges[1], 2, snap[1], srng[1]));
    end

    initial begin
        rst = 1'b1;
        {freq3, freq2, freq1, freq0} = {4'd1, 4'd2, 4'd5, 4'd0};
        rangedisp = 1'b1;
        #130 rst = 1'b0;
        #31 chk("dark_before_tick", {an4, seg4, dp4}, DARK);
        #5  chk("first_d0",  {an4, seg4, dp4}, {4'b1110, 7'b1000000, 1'b1});
        #40 chk("first_d1",  {an4, seg4, dp4}, {4'b1101, 7'b0010010, 1'b1});
        #40 chk("first_d2dp", {an4, seg4, dp4}, {4'b1011, 7'b0100100, 1'b0});
        freq0 = 4'd7;
        #40 chk("first_d3",  {an4, seg4, dp4}, {4'b0111, 7'b1111001, 1'b1});
        #40 chk("new_frame_d0", {an4, seg4, dp4}, {4'b1110, 7'b1111000, 1'b1});
        freq1 = 4'd9;
        #40 chk("stale_d1",  {an4, seg4, dp4}, {4'b1101, 7'b0010010, 1'b1});
        #160 chk("fresh_d1", {an4, seg4, dp4}, {4'b1101, 7'b0010000, 1'b1});
        freq2 = 4'hC;
        #280;
        #3 rst = 1'b1;
        #1 chk("async_rst_d4", {an4, seg4, dp4}, DARK);
        chk("async_rst_d2", {an2, seg2, dp2}, DARK);
        #10 rst = 1'b0;
        #31 chk("dark_3_cycles", {an4, seg4, dp4}, DARK);
        chk("d2_slot0", {an2, seg2, dp2}, {4'b1110, 7'b1111000, 1'b1});
        #5 chk("relit_d0", {an4, seg4, dp4}, {4'b1110, 7'b1111000, 1'b1});
        chk("d2_slot1", {an2, seg2, dp2}, {4'b1101, 7'b0010000, 1'b1});
        {freq3, freq2, freq1, freq0} = {4'd0, 4'd0, 4'd4, 4'd2};
        rangedisp = 1'b0;
        #400;
        rangedisp = 1'b1;
        #400;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
